sdhci_cmd_tx: RTL and testbench
===============================

# sdhci_cmd_tx

Serial transmitter for the SD CMD line inside the SDHCI controller. It sits downstream of the register file that holds the Command and Argument registers, and directly drives the CMD pad signals. The block accepts a command index and argument, then builds the 48-bit command token (start bit, direction bit, index, argument, CRC7, end bit). It shifts the token out MSB-first, one bit per SD clock period, aligned to a falling-edge strobe from the SD clock divider.

## Interface
Parameters:
- none; the frame length is fixed at 48 bits.

Ports:
- `clk_i` in 1: system clock; the only clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `sd_clk_fall_i` in 1: one-cycle strobe marking an SD clock falling edge; all bit changes occur on it.
- `start_i` in 1: command request; handshake with `ready_o`.
- `ready_o` out 1: block idle, accepts `start_i`.
- `cmd_index_i` in 6: command index, sampled on accept.
- `cmd_arg_i` in 32: argument, sampled on accept.
- `busy_o` out 1: a frame is in flight, or the inter-command gap is running.
- `done_o` out 1: one-cycle pulse when the CMD line is released after the end bit.
- `sd_cmd_en_o` out 1: CMD output enable.
- `sd_cmd_o` out 1: CMD output value.

## Operation
- States:
  - IDLE
  - WAIT_FIRST
  - SHIFT
  - GAP (GAP exists only with the macro; see Configuration).
- Accept:
  - A command is accepted when `start_i && ready_o`.
  - On accept, index and argument are latched, the bit counter is set to 0, CRC7 is set to 0, and the state goes to WAIT_FIRST.
- `ready_o = (state == IDLE)`. `busy_o = !ready_o`.
- WAIT_FIRST: on the next `sd_clk_fall_i`, drive bit 0, set `sd_cmd_en_o = 1`, and go to SHIFT.
- Bit k of the frame (k = 0..47) is defined as follows:
  - k = 0: start bit, 0.
  - k = 1: direction bit, 1 (host to card).
  - k = 2..7: index[5:0], MSB first.
  - k = 8..39: argument[31:0], MSB first.
  - k = 40..46: CRC7[6:0], MSB first.
  - k = 47: end bit, 1.
- CRC7:
  - Polynomial x^7+x^3+1, computed serially over bits 0..39 as they are driven.
  - Update: `fb = bit ^ crc[6]`; `crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0)`.
- SHIFT:
  - Each `sd_clk_fall_i` advances the counter and drives the next bit.
  - On the strobe that follows bit 47, the block releases the line: `sd_cmd_en_o = 0`, `sd_cmd_o = 1`, and `done_o` pulses.
  - The next state is then IDLE, or GAP when the macro is defined.
- The bit counter is 6 bits wide and never exceeds 48; there is no wrap-around.

## Timing
Reset values:
- `sd_cmd_en_o = 0`
- `sd_cmd_o = 1`
- `ready_o = 1`
- `busy_o = 0`
- `done_o = 0`
- state = IDLE

Latency and bit timing:
- All outputs are registered.
- Bit k is valid from the cycle after strobe k+1 (counting the first strobe after accept as 1). It holds until the cycle after the next strobe.
- Latency from accept to `done_o` is 49 strobes, plus one cycle.

Boundary conditions:
- `start_i` coinciding with `sd_clk_fall_i` in IDLE: the command is accepted, and that strobe does not drive bit 0. Bit 0 is driven on the next strobe.
- `start_i` while busy: ignored, nothing latched. Changes to `cmd_index_i`/`cmd_arg_i` after accept have no effect.
- Strobes spaced 1 cycle apart (back-to-back): the block must still advance exactly one bit per strobe.
- `rst_ni` low mid-frame: on the next clock edge all outputs return to their reset values. The line is released, and no `done_o` is produced for the aborted frame.
- `done_o` and a new accept cannot occur in the same cycle; `ready_o` rises in the cycle after `done_o` at the earliest.

## Configuration
- Macro: `SDHCI_CMD_TX_NCC_GAP_EN`.
- Defined:
  - After `done_o`, the state GAP counts 8 `sd_clk_fall_i` strobes (N_CC).
  - `ready_o` stays 0 during GAP and rises in the cycle after the 8th strobe.
  - The line stays released throughout GAP.
- Undefined: the GAP state and its counter are absent, and the state goes straight from SHIFT to IDLE.

## Test plan
- CMD0, arg 0x00000000, strobe every 4 cycles:
  - Serial capture on the strobes after bit 0 must read 0x40_00000000_95 (CRC7 0x4A).
  - `done_o` pulses once, and the line is released afterwards.
- CMD8, arg 0x000001AA: capture must read 0x48_000001AA_87.
- CMD17, arg 0x00000000, strobe every cycle:
  - Capture must read 0x51_00000000_55.
  - `sd_cmd_en_o` is high for exactly 48 strobe periods.
- Accept with `start_i` coincident with a strobe; then assert `start_i` again mid-frame with a different index:
  - The first frame is unchanged.
  - The second request is not accepted (`ready_o` = 0).
- Reset asserted at bit 20:
  - Next cycle: `sd_cmd_en_o` = 0, `sd_cmd_o` = 1, `ready_o` = 1, and no `done_o`.
  - A following CMD0 frame is transmitted correctly.
- With `SDHCI_CMD_TX_NCC_GAP_EN` defined:
  - `ready_o` stays low for exactly 8 strobes after `done_o`.
  - Without the macro, `ready_o` is high in the cycle after `done_o`.

Source files
------------

// File: rtl/sdhci_cmd_tx.sv
// SD CMD line serial transmitter: builds the 48-bit command token with CRC7 and shifts it out
// on SD clock falling-edge strobes. Optional N_CC gap after each command: SDHCI_CMD_TX_NCC_GAP_EN.
module sdhci_cmd_tx (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_clk_fall_i,
  input  logic        start_i,
  output logic        ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sd_cmd_en_o,
  output logic        sd_cmd_o
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitFirst = 2'd1;
  localparam logic [1:0] StShift     = 2'd2;
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
  localparam logic [1:0] StGap       = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        cmd_q, cmd_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
  logic [2:0]  gap_q, gap_d;
`endif

  logic [47:0] frame;
  logic [5:0]  bit_pos;
  logic        next_bit;
  logic        fb;
  logic [6:0]  crc_next;

  // CRC field is only read once bits 0..39 have all been folded into crc_q.
  assign frame    = {2'b01, idx_q, arg_q, crc_q, 1'b1};
  assign bit_pos  = 6'd47 - cnt_q;
  assign next_bit = frame[bit_pos];
  assign fb       = next_bit ^ crc_q[6];
  assign crc_next = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    cmd_d   = cmd_q;
    en_d    = en_q;
    done_d  = 1'b0;
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = cmd_index_i;
          arg_d   = cmd_arg_i;
          cnt_d   = 6'd0;
          crc_d   = 7'd0;
          state_d = StWaitFirst;
        end
      end
      StWaitFirst: begin
        if (sd_clk_fall_i) begin
          en_d    = 1'b1;
          cmd_d   = next_bit;
          cnt_d   = cnt_q + 6'd1;
          crc_d   = crc_next;
          state_d = StShift;
        end
      end
      StShift: begin
        // Leave SHIFT one cycle after done so ready never coincides with the done pulse.
        if (done_q) begin
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
          state_d = StGap;
          gap_d   = sd_clk_fall_i ? 3'd1 : 3'd0;
`else
          state_d = StIdle;
`endif
        end else if (sd_clk_fall_i) begin
          if (cnt_q == 6'd48) begin
            en_d   = 1'b0;
            cmd_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            en_d  = 1'b1;
            cmd_d = next_bit;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q < 6'd40) crc_d = crc_next;
          end
        end
      end
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
      StGap: begin
        if (sd_clk_fall_i) begin
          if (gap_q == 3'd7) state_d = StIdle;
          else gap_d = gap_q + 3'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      crc_q   <= 7'd0;
      idx_q   <= 6'd0;
      arg_q   <= 32'd0;
      cmd_q   <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
      gap_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      cmd_q   <= cmd_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef SDHCI_CMD_TX_NCC_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign busy_o      = !ready_o;
  assign done_o      = done_q;
  assign sd_cmd_en_o = en_q;
  assign sd_cmd_o    = cmd_q;

endmodule

// File: tb/tb_sdhci_cmd_tx.sv
// Self-checking bench for sdhci_cmd_tx: known SD command vectors, random frames against a
// frame/CRC7 reference model, strobe spacing, busy restarts and mid-frame reset.
module tb_sdhci_cmd_tx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sd_clk_fall_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  cmd_index_i = '0;
  logic [31:0] cmd_arg_i = '0;
  logic        ready_o, busy_o, done_o, sd_cmd_en_o, sd_cmd_o;

  int checks = 0;
  int errors = 0;

`ifdef SDHCI_CMD_TX_NCC_GAP_EN
  localparam int GapStrobes = 8;
`else
  localparam int GapStrobes = 0;
`endif

  always #5 clk_i = ~clk_i;

  sdhci_cmd_tx dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .sd_clk_fall_i(sd_clk_fall_i),
    .start_i      (start_i),
    .ready_o      (ready_o),
    .cmd_index_i  (cmd_index_i),
    .cmd_arg_i    (cmd_arg_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sd_cmd_en_o  (sd_cmd_en_o),
    .sd_cmd_o     (sd_cmd_o)
  );

  // Reference token: start, direction, index, argument, CRC7 over the first 40 bits, end.
  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    logic [6:0]  crc;
    logic        fb;
    head = {2'b01, idx, arg};
    crc  = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = head[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {head, crc, 1'b1};
  endfunction

  // Sends one command and compares the line cycle by cycle against the strobe-count timeline.
  task automatic drive_frame(input logic [5:0] idx, input logic [31:0] arg, input int period,
                             input bit coincide, input int restart_at, output logic [47:0] cap,
                             output int bad_line, output int done_cnt, output int en_strobes,
                             output int bad_ready);
    logic [47:0] fexp;
    logic [5:0]  pos;
    logic        exp_en, exp_cmd, exp_done, exp_ready;
    bit          strobe;
    int s, ph, cyc, post, endst, limit;
    fexp = frame_of(idx, arg);
    cap = '0; bad_line = 0; done_cnt = 0; en_strobes = 0; bad_ready = 0;
    s = 0; ph = 0; cyc = 0; post = 0;
    endst = 49 + GapStrobes;
    limit = period * (endst + 4) + 10;
    start_i = 1'b1; cmd_index_i = idx; cmd_arg_i = arg; sd_clk_fall_i = coincide;
    @(posedge clk_i); #1;
    start_i = 1'b0; sd_clk_fall_i = 1'b0;
    cmd_index_i = 6'($urandom); cmd_arg_i = $urandom;
    if (ready_o !== 1'b0 || busy_o !== 1'b1) bad_ready++;
    while ((s < endst || post < 2) && cyc < limit) begin
      strobe = (ph == period - 1);
      ph = strobe ? 0 : ph + 1;
      sd_clk_fall_i = strobe;
      if (restart_at > 0 && s == restart_at && strobe) begin
        start_i = 1'b1; cmd_index_i = ~idx;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0; sd_clk_fall_i = 1'b0;
      cyc++;
      if (strobe) s++;
      if (s >= endst) post++;
      exp_en  = (s >= 1 && s <= 48);
      exp_cmd = 1'b1;
      if (exp_en) begin
        pos = 6'(48 - s);
        exp_cmd = fexp[pos];
        if (strobe) cap[pos] = sd_cmd_o;
      end
      if (strobe && sd_cmd_en_o === 1'b1) en_strobes++;
      if (sd_cmd_en_o !== exp_en || sd_cmd_o !== exp_cmd) bad_line++;
      exp_done = strobe && (s == 49);
      if (done_o === 1'b1) done_cnt++;
      if (done_o !== exp_done) bad_line++;
      exp_ready = (GapStrobes == 0) ? (s >= 49 && !exp_done) : (s >= endst);
      if (ready_o !== exp_ready || busy_o !== !exp_ready) bad_ready++;
    end
    if (cyc >= limit) bad_line++;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (sd_cmd_en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", sd_cmd_en_o); end
    checks++; if (sd_cmd_o !== 1'b1) begin errors++; $display("FAIL reset_cmd: got %b expected 1", sd_cmd_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_known(input string name, input logic [5:0] idx, input logic [31:0] arg,
                            input int period, input logic [47:0] want);
    logic [47:0] cap;
    int bl, dc, es, br;
    drive_frame(idx, arg, period, 1'b0, 0, cap, bl, dc, es, br);
    checks++; if (cap !== want) begin errors++; $display("FAIL %s_capture: got %h expected %h", name, cap, want); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, dc); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL %s_line_timing: got %0d bad cycles expected 0", name, bl); end
    checks++; if (br !== 0) begin errors++; $display("FAIL %s_ready: got %0d bad cycles expected 0", name, br); end
    checks++; if (es !== 48) begin errors++; $display("FAIL %s_en_strobes: got %0d expected 48", name, es); end
  endtask

  task automatic test_coincide_restart;
    logic [47:0] cap, want;
    logic [31:0] arg;
    int bl, dc, es, br;
    arg  = $urandom;
    want = frame_of(6'd55, arg);
    drive_frame(6'd55, arg, 3, 1'b1, 20, cap, bl, dc, es, br);
    checks++; if (cap !== want) begin errors++; $display("FAIL restart_capture: got %h expected %h", cap, want); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL restart_line_timing: got %0d bad cycles expected 0", bl); end
    checks++; if (br !== 0) begin errors++; $display("FAIL restart_ready: got %0d bad cycles expected 0", br); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", dc); end
  endtask

  task automatic test_abort_reset;
    logic [47:0] cap;
    bit strobe;
    int s, ph, cyc, dn, en, bl, dc, es, br;
    s = 0; ph = 0; cyc = 0; dn = 0; en = 0;
    start_i = 1'b1; cmd_index_i = 6'd17; cmd_arg_i = $urandom;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (s < 21 && cyc < 200) begin
      strobe = (ph == 1);
      ph = strobe ? 0 : ph + 1;
      sd_clk_fall_i = strobe;
      @(posedge clk_i); #1;
      sd_clk_fall_i = 1'b0;
      cyc++;
      if (strobe) s++;
    end
    checks++; if (sd_cmd_en_o !== 1'b1) begin errors++; $display("FAIL abort_midframe_en: got %b expected 1", sd_cmd_en_o); end
    rst_ni = 1'b0; sd_clk_fall_i = 1'b1;
    @(posedge clk_i); #1;
    sd_clk_fall_i = 1'b0;
    checks++; if (sd_cmd_en_o !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", sd_cmd_en_o); end
    checks++; if (sd_cmd_o !== 1'b1) begin errors++; $display("FAIL abort_cmd: got %b expected 1", sd_cmd_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done_o); end
    rst_ni = 1'b1;
    for (int i = 0; i < 120; i++) begin
      sd_clk_fall_i = (i % 2 == 1);
      @(posedge clk_i); #1;
      sd_clk_fall_i = 1'b0;
      if (done_o === 1'b1) dn++;
      if (sd_cmd_en_o !== 1'b0) en++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn); end
    checks++; if (en !== 0) begin errors++; $display("FAIL abort_line_idle: got %0d driven cycles expected 0", en); end
    drive_frame(6'd0, 32'd0, 2, 1'b0, 0, cap, bl, dc, es, br);
    checks++; if (cap !== 48'h40_0000_0000_95) begin errors++; $display("FAIL abort_next_cmd0: got %h expected %h", cap, 48'h40_0000_0000_95); end
    checks++; if (bl !== 0 || br !== 0) begin errors++; $display("FAIL abort_next_timing: got %0d/%0d bad cycles expected 0/0", bl, br); end
  endtask

  task automatic test_random;
    logic [47:0] cap, want;
    logic [5:0]  idx;
    logic [31:0] arg;
    int per, bl, dc, es, br;
    bit co;
    for (int n = 0; n < 6; n++) begin
      idx  = 6'($urandom);
      arg  = $urandom;
      per  = $urandom_range(1, 5);
      co   = 1'($urandom);
      want = frame_of(idx, arg);
      drive_frame(idx, arg, per, co, 0, cap, bl, dc, es, br);
      checks++; if (cap !== want) begin errors++; $display("FAIL rand%0d_capture: got %h expected %h", n, cap, want); end
      checks++; if (bl !== 0) begin errors++; $display("FAIL rand%0d_line_timing: got %0d bad cycles expected 0", n, bl); end
      checks++; if (br !== 0) begin errors++; $display("FAIL rand%0d_ready: got %0d bad cycles expected 0", n, br); end
      checks++; if (es !== 48) begin errors++; $display("FAIL rand%0d_en_strobes: got %0d expected 48", n, es); end
    end
  endtask

  initial begin
    test_reset();
    test_known("cmd0", 6'd0, 32'h0000_0000, 4, 48'h40_0000_0000_95);
    test_known("cmd8", 6'd8, 32'h0000_01AA, 4, 48'h48_0000_01AA_87);
    test_known("cmd17", 6'd17, 32'h0000_0000, 1, 48'h51_0000_0000_55);
    test_coincide_restart();
    test_abort_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
